serial_addsub: RTL and testbench

SERIAL_ADDSUB -- requirements
Module: serial_addsub

---
 rtl/serial_addsub_pkg.sv | 15 +
 rtl/serial_fa_cell.sv | 17 +
 rtl/serial_addsub.sv | 113 +++++++++++
 tb/tb_serial_addsub.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/serial_addsub_pkg.sv
// Shared types and constants for the bit-serial adder/subtractor.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package serial_addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/serial_fa_cell.sv
// One-bit full adder used by the serial datapath.
// Latency: purely combinational.
// Backpressure: none.
//
// Ports: a, b, cin -> s (sum bit), cout (majority carry).
module serial_fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial add/subtract of two WIDTH-bit operands, one bit per cycle LSB first.
// Latency: done pulses WIDTH edges after the start-accepting edge; back in IDLE one edge later.
// Backpressure: none; start is only honoured in IDLE and is dropped while busy or done.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   start, mode, a, b operation request; mode 0 = a+b, 1 = a-b; sampled on acceptance
//   busy, done        busy high in RUN, done single-cycle pulse when result valid
//   sum, cout, ovf    result, final carry (1 = no borrow on subtract), signed overflow
module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] sum_msb;
    logic [CNT_W-1:0] cnt;
    logic             carry;
    logic             fa_s;
    logic             fa_cout;
    logic             last_bit;

    serial_fa_cell u_fa (
        .a    (a_reg[0]),
        .b    (b_reg[0]),
        .cin  (carry),
        .s    (fa_s),
        .cout (fa_cout)
    );

    assign last_bit = (cnt == CNT_W'(WIDTH - 1));

    // New sum bit enters at the MSB and the register shifts right, so after
    // WIDTH cycles bit 0 has landed in position 0. Written as a shift so it
    // stays legal for WIDTH == 1.
    assign sum_msb = WIDTH'(fa_s) << (WIDTH - 1);

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last_bit) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register and datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            a_reg <= '0;
            b_reg <= '0;
            cnt   <= '0;
            carry <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        // Subtract as a + ~b + 1: invert b and seed the carry with 1.
                        a_reg <= a;
                        b_reg <= (mode == MODE_ADD) ? b : ~b;
                        carry <= (mode == MODE_SUB);
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    sum   <= (sum >> 1) | sum_msb;
                    carry <= fa_cout;
                    a_reg <= a_reg >> 1;
                    b_reg <= b_reg >> 1;
                    cnt   <= cnt + CNT_W'(1);
                    if (last_bit) begin
                        // carry still holds the carry into the MSB here
                        cout <= fa_cout;
                        ovf  <= carry ^ fa_cout;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs
    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

endmodule

// File: tb/tb_serial_addsub.sv
module tb_serial_addsub;

    logic       clk = 1'b0;
    logic       rst;

    logic       start;
    logic       mode;
    logic [7:0] a;
    logic [7:0] b;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;

    logic       start1;
    logic       mode1;
    logic [0:0] a1;
    logic [0:0] b1;
    logic       busy1;
    logic       done1;
    logic [0:0] sum1;
    logic       cout1;
    logic       ovf1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    serial_addsub #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .mode  (mode),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    serial_addsub #(.WIDTH(1)) dut1 (
        .clk   (clk),
        .rst   (rst),
        .start (start1),
        .mode  (mode1),
        .a     (a1),
        .b     (b1),
        .busy  (busy1),
        .done  (done1),
        .sum   (sum1),
        .cout  (cout1),
        .ovf   (ovf1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Launch one 8-bit operation, scramble the inputs after acceptance,
    // and check latency, single done pulse and the result.
    task automatic op8(input string tag, input logic m, input logic [7:0] x, input logic [7:0] y,
                       input logic [7:0] es, input logic ec, input logic eo);
        int lat;
        @(negedge clk);
        start = 1'b1; mode = m; a = x; b = y;
        @(negedge clk);
        start = 1'b0; mode = ~m; a = ~x; b = 8'hA5;
        check({tag, "_busy"}, busy, 1);
        lat = 0;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_lat"}, lat, 8);
        check({tag, "_sum"}, sum, es);
        check({tag, "_cout"}, cout, ec);
        check({tag, "_ovf"}, ovf, eo);
        @(negedge clk);
        check({tag, "_done_pulse"}, {busy, done}, 2'b00);
    endtask

    initial begin
        int lat;
        int npulse;
        logic [7:0] got_sum;

        rst = 1'b1; start = 1'b0; mode = 1'b0; a = '0; b = '0;
        start1 = 1'b0; mode1 = 1'b0; a1 = '0; b1 = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);
        check("rst_ovf", ovf, 0);
        rst = 1'b0;

        op8("add_5a_3c", 1'b0, 8'h5A, 8'h3C, 8'h96, 1'b0, 1'b1);
        op8("sub_10_20", 1'b1, 8'h10, 8'h20, 8'hF0, 1'b0, 1'b0);
        op8("sub_80_01", 1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1);
        op8("sub_33_33", 1'b1, 8'h33, 8'h33, 8'h00, 1'b1, 1'b0);
        op8("add_ff_01", 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0);

        // Result must hold through idle cycles
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_result", {busy, done, cout, ovf, sum}, {1'b0, 1'b0, 1'b1, 1'b0, 8'h00});
        end

        // Second start during RUN is ignored
        @(negedge clk);
        start = 1'b1; mode = 1'b0; a = 8'h5A; b = 8'h3C;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b1; mode = 1'b1; a = 8'h11; b = 8'h22;
        @(negedge clk);
        start = 1'b0;
        npulse = 0;
        got_sum = '0;
        for (int i = 0; i < 15; i++) begin
            if (done) begin
                npulse++;
                got_sum = sum;
            end
            @(negedge clk);
        end
        check("ign_start_pulses", npulse, 1);
        check("ign_start_sum", got_sum, 8'h96);
        check("ign_start_idle", busy, 0);

        // Reset in the middle of RUN aborts without a done pulse
        @(negedge clk);
        start = 1'b1; mode = 1'b0; a = 8'h5A; b = 8'h3C;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_outs", {busy, done, cout, ovf, sum}, 12'h000);
        npulse = 0;
        for (int i = 0; i < 12; i++) begin
            if (done || busy) npulse++;
            @(negedge clk);
        end
        check("midrst_no_done", npulse, 0);
        op8("add_01_01", 1'b0, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0);

        // WIDTH=1 instance: 1+1
        @(negedge clk);
        start1 = 1'b1; mode1 = 1'b0; a1 = 1'b1; b1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0; a1 = 1'b0; b1 = 1'b0;
        check("w1_busy", busy1, 1);
        lat = 0;
        while (!done1 && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check("w1_lat", lat, 1);
        check("w1_res", {sum1, cout1, ovf1}, 3'b011);
        @(negedge clk);
        check("w1_done_pulse", {busy1, done1}, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
